// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5,
    S_RSV6 = 3'd6,
    S_RSV7 = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [1:0] ASRCB_REG  = 2'b00;
  localparam logic [1:0] ASRCB_FOUR = 2'b01;
  localparam logic [1:0] ASRCB_EXT  = 2'b10;
  localparam logic [1:0] ASRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, strobes out.
// The controller uses the slave modport, the datapath side uses master.
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Z;
  logic       MemReady;
  logic       PCWr;
  logic [1:0] Pcsource;
  logic       IRWr;
  logic       IorD;
  logic       MemRd;
  logic       MemWr;
  logic       RegWr;
  logic       RegDst;
  logic       MemToReg;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       ExtOp;
  logic [1:0] Aluc;
  logic       Retire;
  logic       Illegal;
  logic [2:0] State;

  modport slave (
    input  Op, Func, Z, MemReady,
    output PCWr, Pcsource, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemToReg,
           AluSrcA, AluSrcB, ExtOp, Aluc, Retire, Illegal, State
  );

  modport master (
    output Op, Func, Z, MemReady,
    input  PCWr, Pcsource, IRWr, IorD, MemRd, MemWr, RegWr, RegDst, MemToReg,
           AluSrcA, AluSrcB, ExtOp, Aluc, Retire, Illegal, State
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: instruction class flags, legality, and the
// ALU operation / immediate extension used during execute.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output logic [1:0] Aluc_rt,
  output logic       ExtOp,
  output logic       legal,
  output logic       rtype,
  output logic       imm,
  output logic       ld,
  output logic       st,
  output logic       br,
  output logic       jmp
);

  always_comb begin
    Aluc_rt = ALUC_ADD;
    ExtOp   = 1'b0;
    rtype   = 1'b0;
    imm     = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    br      = 1'b0;
    jmp     = 1'b0;
    case (Op)
      OP_RTYPE: begin
        case (Func)
          FN_ADD:  begin rtype = 1'b1; Aluc_rt = ALUC_ADD; end
          FN_SUB:  begin rtype = 1'b1; Aluc_rt = ALUC_SUB; end
          FN_AND:  begin rtype = 1'b1; Aluc_rt = ALUC_AND; end
          FN_OR:   begin rtype = 1'b1; Aluc_rt = ALUC_OR;  end
          default: ;
        endcase
      end
      OP_ADDI: begin imm = 1'b1; ExtOp = 1'b1; end
      // Logical immediates are zero-extended.
      OP_ANDI: begin imm = 1'b1; Aluc_rt = ALUC_AND; end
      OP_ORI:  begin imm = 1'b1; Aluc_rt = ALUC_OR;  end
      OP_LW:   begin ld  = 1'b1; ExtOp = 1'b1; end
      OP_SW:   begin st  = 1'b1; ExtOp = 1'b1; end
      OP_BEQ, OP_BNE: begin br = 1'b1; Aluc_rt = ALUC_SUB; end
      OP_J:    jmp = 1'b1;
      default: ;
    endcase
    legal = rtype | imm | ld | st | br | jmp;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: state register, next-state logic and Moore-style
// strobes qualified by the decoded instruction, Z and MemReady.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               Clrn,
  multicycle_ctrl_if.slave   bus
);

  state_e     state_q, state_d;
  logic [1:0] dec_aluc;
  logic       dec_ext_op, dec_legal, dec_rtype, dec_imm, dec_ld, dec_st, dec_br, dec_jmp;

  logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, retire, illegal;
  logic       iord, reg_dst, mem_to_reg, alu_src_a, ext_op;
  logic [1:0] pc_source, alu_src_b, aluc;

  alu_op_decode u_dec (
    .Op      (bus.Op),
    .Func    (bus.Func),
    .Aluc_rt (dec_aluc),
    .ExtOp   (dec_ext_op),
    .legal   (dec_legal),
    .rtype   (dec_rtype),
    .imm     (dec_imm),
    .ld      (dec_ld),
    .st      (dec_st),
    .br      (dec_br),
    .jmp     (dec_jmp)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    ext_op     = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_b  = ASRCB_REG;
    aluc       = ALUC_ADD;
    case (state_q)
      S_IF: begin
        mem_rd    = 1'b1;
        alu_src_b = ASRCB_FOUR;
        ir_wr     = bus.MemReady;
        pc_wr     = bus.MemReady;
        if (bus.MemReady) state_d = S_ID;
      end
      S_ID: begin
        // Branch target computed here lands in ALUOut for S_EXE.
        alu_src_b = ASRCB_BR;
        if (dec_jmp) begin
          pc_wr     = 1'b1;
          pc_source = PCSRC_JUMP;
          retire    = 1'b1;
          state_d   = S_IF;
        end else if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_src_a = 1'b1;
        aluc      = dec_aluc;
        ext_op    = dec_ext_op;
        if (dec_br) begin
          alu_src_b = ASRCB_REG;
          pc_wr     = (bus.Op == OP_BEQ) ? bus.Z : ~bus.Z;
          pc_source = PCSRC_ALUOUT;
          retire    = 1'b1;
          state_d   = S_IF;
        end else if (dec_rtype) begin
          alu_src_b = ASRCB_REG;
          state_d   = S_WB;
        end else if (dec_imm) begin
          alu_src_b = ASRCB_EXT;
          state_d   = S_WB;
        end else if (dec_ld || dec_st) begin
          alu_src_b = ASRCB_EXT;
          state_d   = S_MEM;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = dec_ld;
        mem_wr = dec_st;
        if (!(dec_ld || dec_st)) begin
          state_d = S_TRAP;
        end else if (bus.MemReady) begin
          retire  = dec_st;
          state_d = dec_ld ? S_WB : S_IF;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        retire     = 1'b1;
        reg_dst    = (bus.Op == OP_RTYPE);
        mem_to_reg = (bus.Op == OP_LW);
        state_d    = S_IF;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes are gated by Clrn so they drop the moment reset asserts.
  assign bus.PCWr     = pc_wr   & Clrn;
  assign bus.IRWr     = ir_wr   & Clrn;
  assign bus.MemRd    = mem_rd  & Clrn;
  assign bus.MemWr    = mem_wr  & Clrn;
  assign bus.RegWr    = reg_wr  & Clrn;
  assign bus.Retire   = retire  & Clrn;
  assign bus.Illegal  = illegal & Clrn;
  assign bus.Pcsource = pc_source;
  assign bus.IorD     = iord;
  assign bus.RegDst   = reg_dst;
  assign bus.MemToReg = mem_to_reg;
  assign bus.AluSrcA  = alu_src_a;
  assign bus.AluSrcB  = alu_src_b;
  assign bus.ExtOp    = ext_op;
  assign bus.Aluc     = aluc;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds the expected per-cycle trace of each
// instruction from its class, then drives MemReady/Z and compares every cycle.
module tb_multicycle_ctrl;

  logic Clk  = 1'b0;
  logic Clrn = 1'b0;
  always #5 Clk = ~Clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.Clk(Clk), .Clrn(Clrn), .bus(bus));

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       irwr, iord, memrd, memwr, regwr, regdst, memtoreg, asrca;
    logic [1:0] asrcb;
    logic       extop;
    logic [1:0] aluc;
    logic       retire, illegal;
  } obs_t;

  typedef struct {
    obs_t o;
    logic mr;
    logic z;
  } step_t;

  step_t plan[$];
  int total = 0;
  int bad   = 0;

  logic [5:0] lop [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C,
                           6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] lfn [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h00,
                           6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input logic [2:0] s);
    obs_t r;
    r = '0;
    r.st = s;
    return r;
  endfunction

  // 0 illegal, 1 R-type, 2 addi, 3 andi, 4 ori, 5 lw, 6 sw, 7 beq, 8 bne, 9 j
  function automatic int kind(input logic [5:0] op, input logic [5:0] func);
    case (op)
      6'h00:   return (func == 6'h20 || func == 6'h22 || func == 6'h24 || func == 6'h25) ? 1 : 0;
      6'h08:   return 2;
      6'h0C:   return 3;
      6'h0D:   return 4;
      6'h23:   return 5;
      6'h2B:   return 6;
      6'h04:   return 7;
      6'h05:   return 8;
      6'h02:   return 9;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.st = bus.State;       r.pcwr = bus.PCWr;        r.pcsrc = bus.Pcsource;
    r.irwr = bus.IRWr;      r.iord = bus.IorD;        r.memrd = bus.MemRd;
    r.memwr = bus.MemWr;    r.regwr = bus.RegWr;      r.regdst = bus.RegDst;
    r.memtoreg = bus.MemToReg; r.asrca = bus.AluSrcA; r.asrcb = bus.AluSrcB;
    r.extop = bus.ExtOp;    r.aluc = bus.Aluc;        r.retire = bus.Retire;
    r.illegal = bus.Illegal;
    return r;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = sample();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // State plus the strobes that reset must force low.
  task automatic check_rst(input string tag);
    logic [9:0] got, exp;
    exp = '0;
    got = {bus.State, bus.PCWr, bus.IRWr, bus.MemRd, bus.MemWr,
           bus.RegWr, bus.Retire, bus.Illegal};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] func, input logic z,
                       input int ifw, input int memw);
    step_t s;
    int k;
    k = kind(op, func);
    plan.delete();
    for (int w = 0; w <= ifw; w++) begin
      s.o = blank(3'd0); s.mr = (w == ifw); s.z = rbit();
      s.o.memrd = 1'b1; s.o.asrcb = 2'b01;
      s.o.irwr = s.mr;  s.o.pcwr = s.mr;
      plan.push_back(s);
    end
    s.o = blank(3'd1); s.o.asrcb = 2'b11; s.mr = rbit(); s.z = rbit();
    if (k == 9) begin
      s.o.pcwr = 1'b1; s.o.pcsrc = 2'b10; s.o.retire = 1'b1;
      plan.push_back(s);
      return;
    end
    plan.push_back(s);
    if (k == 0) begin
      repeat (20) begin
        s.o = blank(3'd5); s.o.illegal = 1'b1; s.mr = rbit(); s.z = rbit();
        plan.push_back(s);
      end
      return;
    end
    s.o = blank(3'd2); s.o.asrca = 1'b1; s.mr = rbit(); s.z = rbit();
    case (k)
      1: s.o.aluc = (func == 6'h22) ? 2'd1 : (func == 6'h24) ? 2'd2 : (func == 6'h25) ? 2'd3 : 2'd0;
      2: begin s.o.asrcb = 2'b10; s.o.extop = 1'b1; end
      3: begin s.o.asrcb = 2'b10; s.o.aluc = 2'b10; end
      4: begin s.o.asrcb = 2'b10; s.o.aluc = 2'b11; end
      5, 6: begin s.o.asrcb = 2'b10; s.o.extop = 1'b1; end
      default: begin
        s.z = z; s.o.aluc = 2'b01; s.o.pcsrc = 2'b01; s.o.retire = 1'b1;
        s.o.pcwr = (k == 7) ? z : ~z;
      end
    endcase
    plan.push_back(s);
    if (k >= 7) return;
    if (k == 5 || k == 6) begin
      for (int w = 0; w <= memw; w++) begin
        s.o = blank(3'd3); s.o.iord = 1'b1; s.mr = (w == memw); s.z = rbit();
        s.o.memrd = (k == 5); s.o.memwr = (k == 6);
        s.o.retire = (k == 6) && s.mr;
        plan.push_back(s);
      end
      if (k == 6) return;
    end
    s.o = blank(3'd4); s.o.regwr = 1'b1; s.o.retire = 1'b1; s.mr = rbit(); s.z = rbit();
    s.o.regdst = (k == 1); s.o.memtoreg = (k == 5);
    plan.push_back(s);
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] func,
                     input int limit);
    for (int i = 0; i < plan.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      @(posedge Clk);
      #1;
      if (i == 0) begin bus.Op = op; bus.Func = func; end
      bus.MemReady = plan[i].mr;
      bus.Z        = plan[i].z;
      @(negedge Clk);
      check($sformatf("%s[%0d]", tag, i), plan[i].o);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge Clk);
    #3;
    Clrn = 1'b0;
    bus.MemReady = 1'b0;
    #1 check_rst({tag, "_async"});
    @(negedge Clk);
    check_rst({tag, "_hold"});
    Clrn = 1'b1;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] func,
                          input logic z, input int ifw, input int memw);
    build(op, func, z, ifw, memw);
    $display("txn %-8s op=%h func=%h z=%0d ifw=%0d memw=%0d cycles=%0d",
             tag, op, func, z, ifw, memw, plan.size());
    run(tag, op, func, -1);
    if (kind(op, func) == 0) reset_pulse({tag, "_rst"});
  endtask

  initial begin
    logic [5:0] op, func;
    int idx;
    bus.Op = 6'h00; bus.Func = 6'h00; bus.Z = 1'b0; bus.MemReady = 1'b0;
    #12 check_rst("reset_async");
    @(negedge Clk);
    check_rst("reset_hold");
    Clrn = 1'b1;

    do_instr("add",     6'h00, 6'h20, 1'b0, 0, 0);
    do_instr("lw_wait", 6'h23, 6'h00, 1'b0, 0, 3);
    do_instr("beq_z1",  6'h04, 6'h00, 1'b1, 0, 0);
    do_instr("beq_z0",  6'h04, 6'h00, 1'b0, 0, 0);
    do_instr("bne_z1",  6'h05, 6'h00, 1'b1, 0, 0);
    do_instr("bne_z0",  6'h05, 6'h00, 1'b0, 0, 0);
    do_instr("ori",     6'h0D, 6'h00, 1'b0, 0, 0);
    do_instr("sub",     6'h00, 6'h22, 1'b0, 0, 0);
    do_instr("j",       6'h02, 6'h00, 1'b0, 0, 0);
    do_instr("sw",      6'h2B, 6'h00, 1'b0, 2, 1);
    do_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0);

    // Reset dropped while sw is waiting in S_MEM with MemWr high.
    build(6'h2B, 6'h11, 1'b0, 0, 3);
    $display("txn %-8s op=%h func=%h cycles=%0d", "sw_abort", 6'h2B, 6'h11, 4);
    run("sw_abort", 6'h2B, 6'h11, 4);
    #2 Clrn = 1'b0;
    #1 check_rst("sw_abort_async");
    @(negedge Clk);
    Clrn = 1'b1;
    bus.MemReady = 1'b0;

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 11);
      op  = lop[idx];
      func = (op == 6'h00) ? lfn[idx] : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) begin
        op   = rbit() ? 6'h3F : 6'h00;
        func = 6'h27;
      end
      do_instr($sformatf("rnd%0d", n), op, func, rbit(),
               $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
